// File: rtl/index_ram_writer.sv
// index_ram_writer
//   Write-side engine for the 640x480 8-bit frame index RAM. Paint commands
//   (square brush stamp, full-screen clear) arrive over a valid/ready
//   handshake. Each command is expanded into one pixel write per clock,
//   in row-major order, on the RAM write port. The scan-out path reads the
//   RAM on its other port.
//
// Ports
//   iVGA_CLK   : pixel clock, all logic on the rising edge
//   iRST_n     : asynchronous active-low reset
//   cmd_valid  : command present
//   cmd_ready  : engine idle; command taken when valid & ready at an edge
//   cmd_op     : 0 = brush, 1 = clear, 2/3 = reserved (treated as empty)
//   cmd_x/y    : brush top-left column/row
//   cmd_size   : brush side length in pixels (0..63)
//   cmd_index  : color index to write
//   wr_addr    : RAM write address (registered)
//   wr_data    : RAM write data (registered)
//   wr_en      : RAM write enable (registered)
//   busy       : inverse of cmd_ready
//   done       : one-cycle pulse when a command completes
module index_ram_writer #(
  parameter int H_RES  = 640,
  parameter int V_RES  = 480,
  parameter int ADDR_W = 19,
  parameter int IDX_W  = 8
) (
  input  logic              iVGA_CLK,
  input  logic              iRST_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [9:0]        cmd_x,
  input  logic [8:0]        cmd_y,
  input  logic [5:0]        cmd_size,
  input  logic [IDX_W-1:0]  cmd_index,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [IDX_W-1:0]  wr_data,
  output logic              wr_en,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_WRITE, S_DONE} state_t;

  localparam logic [10:0]       X_LIM = 11'(H_RES);
  localparam logic [10:0]       Y_LIM = 11'(V_RES);
  localparam logic [10:0]       X_MAX = 11'(H_RES - 1);
  localparam logic [10:0]       Y_MAX = 11'(V_RES - 1);
  localparam logic [ADDR_W-1:0] LINE  = ADDR_W'(H_RES);

  state_t            state_q;
  logic [9:0]        x0_q, x1_q, x_q;
  logic [8:0]        y0_q, y1_q, y_q;
  logic              empty_q;
  logic [IDX_W-1:0]  idx_q;
  logic [ADDR_W-1:0] row_base_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [IDX_W-1:0]  wr_data_q;
  logic              wr_en_q;
  logic              done_q;

  logic [10:0]       x_end, y_end;
  logic [9:0]        x0_d, x1_d;
  logic [8:0]        y0_d, y1_d;
  logic              empty_d;
  logic [ADDR_W-1:0] row_base_d;
  logic [ADDR_W-1:0] row_next;

  always_comb begin
    // 11-bit bound sums cannot wrap for any in-range start + 63.
    x_end   = {1'b0, cmd_x} + 11'(cmd_size) - 11'd1;
    y_end   = {2'b0, cmd_y} + 11'(cmd_size) - 11'd1;
    x0_d    = cmd_x;
    y0_d    = cmd_y;
    x1_d    = (x_end > X_MAX) ? X_MAX[9:0] : x_end[9:0];
    y1_d    = (y_end > Y_MAX) ? Y_MAX[8:0] : y_end[8:0];
    empty_d = 1'b0;
    if (cmd_op == 2'd1) begin
      x0_d = '0;
      y0_d = '0;
      x1_d = X_MAX[9:0];
      y1_d = Y_MAX[8:0];
    end else if (cmd_op == 2'd0) begin
      // size 0 makes x_end/y_end meaningless, but the command is empty anyway
      empty_d = (cmd_size == 6'd0) || ({1'b0, cmd_x} >= X_LIM) ||
                ({2'b0, cmd_y} >= Y_LIM);
    end else begin
      empty_d = 1'b1;
    end
    // y0 * 640 as shift-add, no multiplier
    row_base_d = (ADDR_W'(y0_q) << 9) + (ADDR_W'(y0_q) << 7);
    row_next   = row_base_q + LINE;
  end

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state_q    <= S_IDLE;
      x0_q       <= '0;
      x1_q       <= '0;
      x_q        <= '0;
      y0_q       <= '0;
      y1_q       <= '0;
      y_q        <= '0;
      empty_q    <= 1'b0;
      idx_q      <= '0;
      row_base_q <= '0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      wr_en_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q  <= 1'b0;
          wr_en_q <= 1'b0;
          if (cmd_valid) begin
            x0_q    <= x0_d;
            x1_q    <= x1_d;
            y0_q    <= y0_d;
            y1_q    <= y1_d;
            empty_q <= empty_d;
            idx_q   <= cmd_index;
            state_q <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (empty_q) begin
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            // Issue the first pixel straight from the freshly computed base.
            row_base_q <= row_base_d;
            x_q        <= x0_q;
            y_q        <= y0_q;
            wr_addr_q  <= row_base_d + ADDR_W'(x0_q);
            wr_data_q  <= idx_q;
            wr_en_q    <= 1'b1;
            state_q    <= S_WRITE;
          end
        end
        S_WRITE: begin
          // x_q/y_q name the pixel currently on the write port.
          if ((x_q == x1_q) && (y_q == y1_q)) begin
            wr_en_q <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else if (x_q == x1_q) begin
            x_q        <= x0_q;
            y_q        <= y_q + 9'd1;
            row_base_q <= row_next;
            wr_addr_q  <= row_next + ADDR_W'(x0_q);
          end else begin
            x_q       <= x_q + 10'd1;
            wr_addr_q <= wr_addr_q + ADDR_W'(1);
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          wr_en_q <= 1'b0;
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign busy      = ~cmd_ready;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign wr_en     = wr_en_q;
  assign done      = done_q;

endmodule

// File: tb/tb_index_ram_writer.sv
// Directed bench for index_ram_writer: brush, clipped brush, empty commands,
// back-to-back accept, and asynchronous reset during a clear.
module tb_index_ram_writer;

  logic        iVGA_CLK = 1'b0;
  logic        iRST_n   = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = '0;
  logic [9:0]  cmd_x = '0;
  logic [8:0]  cmd_y = '0;
  logic [5:0]  cmd_size = '0;
  logic [7:0]  cmd_index = '0;
  logic [18:0] wr_addr;
  logic [7:0]  wr_data;
  logic        wr_en;
  logic        busy;
  logic        done;

  index_ram_writer dut (
    .iVGA_CLK (iVGA_CLK),
    .iRST_n   (iRST_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op   (cmd_op),
    .cmd_x    (cmd_x),
    .cmd_y    (cmd_y),
    .cmd_size (cmd_size),
    .cmd_index(cmd_index),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_en    (wr_en),
    .busy     (busy),
    .done     (done)
  );

  always #5 iVGA_CLK = ~iVGA_CLK;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // Results of the last do_cmd: cycle numbers count negedges after the accept edge.
  int          n_wr, first_c, last_c, done_c, dat_err;
  logic [18:0] wr_q[$];

  task automatic do_cmd(input logic [1:0] op, input logic [9:0] x, input logic [8:0] y,
                        input logic [5:0] sz, input logic [7:0] idx, input int budget);
    n_wr = 0; first_c = -1; last_c = -1; done_c = -1; dat_err = 0;
    wr_q.delete();
    @(negedge iVGA_CLK);
    chk("ready_before_cmd", cmd_ready, 1);
    cmd_op = op; cmd_x = x; cmd_y = y; cmd_size = sz; cmd_index = idx;
    cmd_valid = 1'b1;
    @(posedge iVGA_CLK);
    #1;
    cmd_valid = 1'b0;
    // Scramble inputs; they must be ignored while busy.
    cmd_op = 2'd1; cmd_x = 10'd3; cmd_y = 9'd3; cmd_size = 6'd63; cmd_index = 8'hFF;
    for (int c = 1; c <= budget; c++) begin
      @(negedge iVGA_CLK);
      if (wr_en) begin
        if (first_c < 0) first_c = c;
        last_c = c;
        wr_q.push_back(wr_addr);
        if (wr_data !== idx) dat_err++;
        n_wr++;
      end
      if (done) begin
        done_c = c;
        break;
      end
    end
    @(negedge iVGA_CLK);
    chk("ready_after_done", cmd_ready, 1);
    chk("done_one_cycle", done, 0);
  endtask

  task automatic chk_addrs(input string tag, input logic [18:0] exp[]);
    logic [31:0] got;
    chk({tag, "_count"}, n_wr, exp.size());
    for (int i = 0; i < exp.size(); i++) begin
      got = (i < wr_q.size()) ? 32'(wr_q[i]) : 32'hFFFF_FFFF;
      chk({tag, "_addr"}, got, 32'(exp[i]));
    end
    chk({tag, "_data"}, dat_err, 0);
  endtask

  initial begin
    logic [18:0] exp_a[];
    int          cnt, err, acc_c, doneA, doneB, firstB;
    int          a_n, b_n, a_err, b_err;

    // ---- reset state
    #12;
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_done", done, 0);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    @(negedge iVGA_CLK);
    iRST_n = 1'b1;
    repeat (2) @(negedge iVGA_CLK);

    // ---- brush (10,20) size 4
    do_cmd(2'd0, 10'd10, 9'd20, 6'd4, 8'h2A, 100);
    exp_a = '{19'd12810, 19'd12811, 19'd12812, 19'd12813,
              19'd13450, 19'd13451, 19'd13452, 19'd13453,
              19'd14090, 19'd14091, 19'd14092, 19'd14093,
              19'd14730, 19'd14731, 19'd14732, 19'd14733};
    chk_addrs("brush", exp_a);
    chk("brush_first_cycle", first_c, 2);
    chk("brush_last_cycle", last_c, 17);
    chk("brush_done_cycle", done_c, 18);

    // ---- clipped brush at the bottom-right corner
    do_cmd(2'd0, 10'd638, 9'd478, 6'd4, 8'h5C, 100);
    exp_a = '{19'd306558, 19'd306559, 19'd307198, 19'd307199};
    chk_addrs("clip", exp_a);
    chk("clip_no_gap", last_c - first_c + 1, 4);
    chk("clip_done_cycle", done_c, last_c + 1);

    // ---- empty commands
    do_cmd(2'd0, 10'd640, 9'd0, 6'd4, 8'h01, 20);
    chk("empty_x_writes", n_wr, 0);
    chk("empty_x_done", done_c, 2);
    do_cmd(2'd0, 10'd5, 9'd5, 6'd0, 8'h01, 20);
    chk("empty_size_writes", n_wr, 0);
    chk("empty_size_done", done_c, 2);
    do_cmd(2'd3, 10'd5, 9'd5, 6'd4, 8'h01, 20);
    chk("empty_op_writes", n_wr, 0);
    chk("empty_op_done", done_c, 2);
    do_cmd(2'd0, 10'd5, 9'd480, 6'd4, 8'h01, 20);
    chk("empty_y_writes", n_wr, 0);

    // ---- back-to-back: A brush (0,0) size 2 idx 0x11, B brush (100,1) size 1 idx 0x22
    @(negedge iVGA_CLK);
    cmd_op = 2'd0; cmd_x = 10'd0; cmd_y = 9'd0; cmd_size = 6'd2; cmd_index = 8'h11;
    cmd_valid = 1'b1;
    @(posedge iVGA_CLK);
    #1;
    cmd_x = 10'd100; cmd_y = 9'd1; cmd_size = 6'd1; cmd_index = 8'h22;
    acc_c = -1; doneA = -1; doneB = -1; firstB = -1;
    a_n = 0; b_n = 0; a_err = 0; b_err = 0;
    exp_a = '{19'd0, 19'd1, 19'd640, 19'd641};
    for (int c = 1; c <= 60; c++) begin
      @(negedge iVGA_CLK);
      if (acc_c >= 0 && cmd_valid) cmd_valid = 1'b0;
      if (wr_en) begin
        if (doneA < 0) begin
          if (a_n >= 4 || wr_addr !== exp_a[a_n] || wr_data !== 8'h11) a_err++;
          a_n++;
        end else begin
          if (firstB < 0) firstB = c;
          if (wr_addr !== 19'd740 || wr_data !== 8'h22) b_err++;
          b_n++;
        end
      end
      if (done) begin
        if (doneA < 0) doneA = c;
        else begin doneB = c; break; end
      end
      if (cmd_ready && cmd_valid && doneA >= 0 && acc_c < 0) acc_c = c;
    end
    chk("b2b_a_writes", a_n, 4);
    chk("b2b_a_err", a_err, 0);
    chk("b2b_a_done", doneA, 6);
    chk("b2b_accept_cycle", acc_c, doneA + 1);
    chk("b2b_b_first", firstB, acc_c + 2);
    chk("b2b_b_writes", b_n, 1);
    chk("b2b_b_err", b_err, 0);
    chk("b2b_b_done", doneB, firstB + 1);

    // ---- clear, reset after 1000 writes
    @(negedge iVGA_CLK);
    cmd_op = 2'd1; cmd_index = 8'h00; cmd_valid = 1'b1;
    @(posedge iVGA_CLK);
    #1;
    cmd_valid = 1'b0;
    cnt = 0; err = 0; first_c = -1;
    for (int c = 1; c <= 1100 && cnt < 1000; c++) begin
      @(negedge iVGA_CLK);
      if (wr_en) begin
        if (first_c < 0) first_c = c;
        if (wr_addr !== 19'(cnt) || wr_data !== 8'h00) err++;
        cnt++;
      end else if (first_c >= 0) begin
        err++;
      end
    end
    chk("clear_writes", cnt, 1000);
    chk("clear_first_cycle", first_c, 2);
    chk("clear_contig", err, 0);
    chk("clear_busy", busy, 1);
    #2;
    iRST_n = 1'b0;
    #1;
    chk("arst_wr_en", wr_en, 0);
    chk("arst_ready", cmd_ready, 1);
    chk("arst_addr", wr_addr, 0);
    @(negedge iVGA_CLK);
    iRST_n = 1'b1;
    cnt = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge iVGA_CLK);
      if (wr_en || done || !cmd_ready) cnt++;
    end
    chk("post_rst_idle", cnt, 0);

    // ---- engine works again after reset
    do_cmd(2'd0, 10'd5, 9'd5, 6'd1, 8'h77, 20);
    exp_a = '{19'd3205};
    chk_addrs("post_rst_brush", exp_a);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
